// File: rtl/bitline_serial_subtractor.sv
// bitline_serial_subtractor
//   Bit-serial unsigned subtractor (x - y) fed LSB first, one bit pair per
//   accepted cycle. Each difference bit is registered and emitted one cycle
//   after acceptance. The full WIDTH-bit difference and the final borrow are
//   held until the consumer acknowledges them.
//
// Ports
//   clk, rst_n              : clock, synchronous active-low reset
//   start                   : begin an operation (IDLE, or DONE with result_ack)
//   bit_valid               : x_bitline / y_bitline carry a bit pair
//   x_bitline, y_bitline    : minuend / subtrahend bits, LSB first
//   busy                    : operation in progress
//   diff_bit, diff_valid    : registered difference bit and its one-cycle qualifier
//   result, borrow_out      : assembled difference and underflow flag (valid while done)
//   done                    : result held for the consumer
//   result_ack              : consumer accepts result
module bitline_serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             x_bitline,
  input  logic             y_bitline,
  output logic             busy,
  output logic             diff_bit,
  output logic             diff_valid,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out,
  output logic             done,
  input  logic             result_ack
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH-1);

  state_t           r_state, w_state_nxt;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_diff_bit, r_diff_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_borrow_out;

  logic             w_init, w_accept, w_last;
  logic             w_d, w_borrow_nxt;
  logic [WIDTH-1:0] w_shreg_nxt;

  // Full-subtractor cell on the current bit pair and running borrow.
  assign w_d          = x_bitline ^ y_bitline ^ r_borrow;
  assign w_borrow_nxt = (~x_bitline & y_bitline) | (~(x_bitline ^ y_bitline) & r_borrow);
  // LSB-first bits enter at the top; after WIDTH shifts bit 0 sits at [0].
  assign w_shreg_nxt  = {w_d, r_shreg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_init      = 1'b1;
        end
      end
      S_RUN: begin
        if (bit_valid) begin
          w_accept = 1'b1;
          if (r_cnt == LAST_CNT) begin
            w_last      = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        // start alone is ignored; with ack it chains straight into a new run
        if (result_ack) begin
          if (start) begin
            w_state_nxt = S_RUN;
            w_init      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_diff_bit   <= 1'b0;
      r_diff_valid <= 1'b0;
      r_result     <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      r_diff_valid <= w_accept;
      if (w_init) begin
        r_borrow <= 1'b0;
        r_cnt    <= '0;
        r_shreg  <= '0;
      end else if (w_accept) begin
        r_diff_bit <= w_d;
        r_borrow   <= w_borrow_nxt;
        r_cnt      <= r_cnt + 1'b1;
        r_shreg    <= w_shreg_nxt;
        if (w_last) begin
          r_result     <= w_shreg_nxt;
          r_borrow_out <= w_borrow_nxt;
        end
      end
    end
  end

  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign diff_bit   = r_diff_bit;
  assign diff_valid = r_diff_valid;
  assign result     = r_result;
  assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_bitline_serial_subtractor.sv
module tb_bitline_serial_subtractor;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, bit_valid, x_bitline, y_bitline, result_ack;
  logic             busy, diff_bit, diff_valid, borrow_out, done;
  logic [WIDTH-1:0] result;

  int n_asrt = 0;
  int n_fail = 0;

  bitline_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
    .x_bitline(x_bitline), .y_bitline(y_bitline), .busy(busy),
    .diff_bit(diff_bit), .diff_valid(diff_valid), .result(result),
    .borrow_out(borrow_out), .done(done), .result_ack(result_ack)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full subtraction. stall_before[i] inserts one bit_valid=0 cycle
  // (with a spurious start pulse) ahead of bit i. Assumes DUT is in IDLE,
  // or in DONE when with_ack is set. Leaves the DUT in DONE.
  task automatic do_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] exp_r, input logic exp_b,
                       input logic [7:0] stall_before, input logic with_ack,
                       input int exp_lat);
    int cyc;
    start = 1'b1; result_ack = with_ack; bit_valid = 1'b0;
    tick();
    start = 1'b0; result_ack = 1'b0;
    cyc = 1;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_done_start"}, 32'(done), 32'd0);
    for (int i = 0; i < WIDTH; i++) begin
      if (stall_before[i]) begin
        bit_valid = 1'b0; start = 1'b1;
        x_bitline = ~x[i]; y_bitline = y[i];
        tick(); cyc++;
        start = 1'b0;
        chk({tag, "_stall_dv"}, 32'(diff_valid), 32'd0);
        chk({tag, "_stall_busy"}, 32'(busy), 32'd1);
      end
      bit_valid = 1'b1; x_bitline = x[i]; y_bitline = y[i];
      tick(); cyc++;
      bit_valid = 1'b0;
      chk($sformatf("%s_dv%0d", tag, i), 32'(diff_valid), 32'd1);
      chk($sformatf("%s_db%0d", tag, i), 32'(diff_bit), 32'(exp_r[i]));
      if (i < WIDTH-1) chk($sformatf("%s_nd%0d", tag, i), 32'(done), 32'd0);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_result"}, 32'(result), 32'(exp_r));
    chk({tag, "_borrow"}, 32'(borrow_out), 32'(exp_b));
  endtask

  // Release a DONE result with result_ack and no start.
  task automatic release_done(input string tag);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0;
    x_bitline = 1'b0; y_bitline = 1'b0; result_ack = 1'b0;
    tick(); tick();
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_dv",    32'(diff_valid), 32'd0);
    chk("rst_db",    32'(diff_bit), 32'd0);
    chk("rst_res",   32'(result), 32'd0);
    chk("rst_bo",    32'(borrow_out), 32'd0);
    rst_n = 1'b1;

    // bit_valid in IDLE is ignored
    bit_valid = 1'b1; x_bitline = 1'b1;
    tick();
    bit_valid = 1'b0;
    chk("idle_bv_dv",   32'(diff_valid), 32'd0);
    chk("idle_bv_busy", 32'(busy), 32'd0);

    // 100 - 37 = 63
    do_op("a", 8'd100, 8'd37, 8'd63, 1'b0, 8'h00, 1'b0, 9);
    release_done("a");

    // 37 - 100 = 193 with borrow; held until ack, start alone ignored
    do_op("b", 8'd37, 8'd100, 8'hC1, 1'b1, 8'h00, 1'b0, 9);
    start = 1'b1; bit_valid = 1'b1; x_bitline = 1'b1;
    tick();
    start = 1'b0; bit_valid = 1'b0;
    chk("b_hold_done", 32'(done), 32'd1);
    chk("b_hold_busy", 32'(busy), 32'd0);
    chk("b_hold_dv",   32'(diff_valid), 32'd0);
    chk("b_hold_res",  32'(result), 32'hC1);
    chk("b_hold_bo",   32'(borrow_out), 32'd1);
    tick();
    chk("b_hold2_done", 32'(done), 32'd1);
    release_done("b");

    // 0 - 1 = FF, borrow
    do_op("c", 8'd0, 8'd1, 8'hFF, 1'b1, 8'h00, 1'b0, 9);
    release_done("c");
    // equal operands
    do_op("d", 8'h55, 8'h55, 8'h00, 1'b0, 8'h00, 1'b0, 9);
    release_done("d");

    // three stall cycles mid-stream, spurious start during RUN
    do_op("e", 8'd100, 8'd37, 8'd63, 1'b0, 8'b0010_1010, 1'b0, 12);
    release_done("e");

    // abort after 4 accepted bits (200 - 55 operands)
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; x_bitline = 1'(8'd200 >> i); y_bitline = 1'(8'd55 >> i);
      tick();
    end
    bit_valid = 1'b0;
    chk("abort_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dv",   32'(diff_valid), 32'd0);
    chk("abort_db",   32'(diff_bit), 32'd0);
    chk("abort_res",  32'(result), 32'd0);
    chk("abort_bo",   32'(borrow_out), 32'd0);

    // fresh run after abort: 200 - 55 = 145
    do_op("f", 8'd200, 8'd55, 8'd145, 1'b0, 8'h00, 1'b0, 9);
    // back-to-back: ack + start in DONE, 5 - 9 = 252 with borrow
    do_op("g", 8'd5, 8'd9, 8'd252, 1'b1, 8'h00, 1'b1, 9);
    release_done("g");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/bitline_serial_subtractor.md
Name: bitline_serial_subtractor

Overview:
- Bit-serial subtractor for the bitline compute datapath. Computes x − y, where the operands arrive one bit pair per cycle on the bitlines, least significant bit (LSB) first.
- Tracks the borrow chain and emits each difference bit one cycle after it is accepted.
- Assembles the full WIDTH-bit result and the final borrow. Both are held for the downstream consumer until it acknowledges them.
- It is the inverse operation to the carry-generating add cells. Address/result write-back logic uses it for subtract and compare operations.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- start  input  1  begin a new subtraction; honoured only in IDLE, or in DONE together with result_ack
- bit_valid  input  1  x_bitline/y_bitline carry a valid bit pair this cycle
- x_bitline  input  1  minuend bit, LSB first
- y_bitline  input  1  subtrahend bit, LSB first
- busy  output  1  high in RUN
- diff_bit  output  1  registered difference bit
- diff_valid  output  1  one-cycle pulse qualifying diff_bit
- result  output  WIDTH  assembled difference, valid while done=1
- borrow_out  output  1  final borrow (1 ⇔ x < y, unsigned), valid while done=1
- done  output  1  result/borrow_out held valid
- result_ack  input  1  consumer accepts the result

Behaviour:
- Reset applies when rst_n=0 at a clk edge. It forces:
  - state=IDLE, busy=0, done=0, diff_valid=0;
  - diff_bit=0, result=0, borrow_out=0;
  - internal borrow=0, count=0.
- Reset mid-RUN or mid-DONE aborts the operation with no partial output. All inputs are ignored while rst_n=0.
- IDLE:
  - start=1 → RUN next cycle; borrow←0, count←0, shift register←0.
  - bit_valid is ignored in IDLE.
- RUN (busy=1):
  - On each cycle with bit_valid=1, with b the current borrow:
    - d = x^y^b;
    - next borrow = (~x&y) | (~(x^y)&b);
    - diff_bit←d and diff_valid←1 on the next edge (1-cycle latency);
    - shift register ← {d, shreg[WIDTH-1:1]}, so LSB-first bits land in the correct positions after WIDTH shifts;
    - count←count+1.
  - On cycles with bit_valid=0: stall; state, borrow and count hold, and diff_valid←0.
  - start is ignored in RUN.
  - When the WIDTH-th bit is accepted (count==WIDTH-1 && bit_valid), the next edge:
    - → DONE;
    - result←final shift register value;
    - borrow_out←final borrow;
    - done←1.
  - The last diff_valid pulse coincides with the first cycle of done=1.
- DONE (done=1):
  - result and borrow_out are stable; bit_valid is ignored.
  - result_ack=1, start=0 → IDLE; done←0. result and borrow_out keep their values, but they are undefined for the consumer once done=0.
  - result_ack=1, start=1 → RUN directly (back-to-back), with the same initialisation as from IDLE.
  - start alone is ignored.
- Arithmetic is modulo 2^WIDTH, unsigned; borrow_out is the unsigned underflow flag.
- Total latency: start-to-done = WIDTH+1 cycles with no stalls, plus one cycle for each bit_valid=0 cycle in RUN.

Test Plan:
- WIDTH=8, start, then 8 consecutive bit pairs x=100, y=37 LSB first → 8 diff_valid pulses, bits 1,1,1,1,1,1,0,0; done asserts 9 cycles after start; result=63, borrow_out=0.
- x=37, y=100 → result=8'hC1 (193), borrow_out=1; done held until result_ack, then IDLE.
- x=0, y=1 → result=8'hFF, borrow_out=1. Separately, x=8'h55, y=8'h55 → result=0, borrow_out=0.
- x=100, y=37 with bit_valid deasserted for 3 random cycles mid-stream → identical result=63, borrow_out=0; done 12 cycles after start; no diff_valid during stall cycles; start pulsed during RUN has no effect.
- rst_n=0 after 4 accepted bits → next cycle all outputs 0, state IDLE. A fresh run of x=200, y=55 then gives result=145, borrow_out=0 with no residue from the aborted run.
- DONE with result_ack=1 and start=1 in the same cycle → busy=1 next cycle; second operation x=5, y=9 yields result=252, borrow_out=1.
